tlk2711_axil_reg_bridge: RTL

AXI4-Lite slave that converts PS register-bus transactions (HPM port) into the single-cycle register write/read strobes consumed by tlk2711_top (i_reg_wen/waddr/wdata, i_reg_ren/raddr, o_reg_rdata). It sits directly upstream of tlk2711_top's register interface. Accesses are 64-bit and serialised: one transaction in flight at a time.

---
 rtl/tlk2711_pkg.sv | 19 +
 rtl/tlk2711_axil_hold_reg.sv | 30 +++
 rtl/tlk2711_axil_reg_bridge.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared register-bus constants, AXI response codes and bridge FSM states.
package tlk2711_pkg;
  localparam int REG_DATA_WIDTH = 64;
  localparam int REG_ADDR_WIDTH = 16;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STROBE,
    ST_WR_RESP,
    ST_RD_STROBE,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;
  function automatic logic [1:0] access_resp(input logic out_of_span, input logic malformed);
    return out_of_span ? RESP_DECERR : malformed ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/tlk2711_axil_hold_reg.sv
// tlk2711_axil_hold_reg: single-entry valid/data holding register for one AXI-Lite request channel.
module tlk2711_axil_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_ready,
  output logic         o_held,
  output logic [W-1:0] o_data
);
  logic         r_held;
  logic [W-1:0] r_data;
  assign o_ready = i_en & ~r_held;
  assign o_held  = r_held;
  assign o_data  = r_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_held <= 1'b0;
      r_data <= '0;
    end else if (i_clr) begin
      r_held <= 1'b0;
    end else if (o_ready && i_valid) begin
      r_held <= 1'b1;
      r_data <= i_data;
    end
endmodule

// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge: serialising AXI4-Lite slave driving tlk2711_top register strobes.
// Define TLK2711_AXIL_RANGE_CHECK_EN to answer addresses at or beyond REG_SPAN with DECERR.
module tlk2711_axil_reg_bridge
  import tlk2711_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 16,
  parameter int                        RD_LATENCY     = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] REG_SPAN       = 'h100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  input  logic [63:0]               s_axil_wdata,
  input  logic [7:0]                s_axil_wstrb,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  output logic [1:0]                s_axil_bresp,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [63:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      o_reg_wen,
  output logic [15:0]               o_reg_waddr,
  output logic [63:0]               o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [15:0]               o_reg_raddr,
  input  logic [63:0]               i_reg_rdata
);
`ifdef TLK2711_AXIL_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam logic [1:0] LAT = 2'(RD_LATENCY);
  state_t                    r_state, w_next;
  logic                      r_run, r_last_wr;
  logic [1:0]                r_cnt, r_bresp, r_rresp;
  logic [63:0]               r_rdata;
  logic                      w_idle, w_en, w_b_done, w_r_done;
  logic                      w_aw_held, w_w_held, w_ar_held;
  logic [AXI_ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic [71:0]               w_wd;
  logic [1:0]                w_wr_resp, w_rd_resp;
  logic                      w_gnt_wr, w_gnt_rd, w_cap;
  // r_run keeps every ready low while reset is asserted and for the first cycle after
  assign w_idle   = r_state == ST_IDLE;
  assign w_en     = r_run & w_idle;
  assign w_b_done = (r_state == ST_WR_RESP) & s_axil_bready;
  assign w_r_done = (r_state == ST_RD_RESP) & s_axil_rready;
  tlk2711_axil_hold_reg #(.W(AXI_ADDR_WIDTH)) u_aw (
    .clk(clk), .rst(rst), .i_en(w_en), .i_valid(s_axil_awvalid), .i_data(s_axil_awaddr),
    .i_clr(w_b_done), .o_ready(s_axil_awready), .o_held(w_aw_held), .o_data(w_awaddr)
  );
  tlk2711_axil_hold_reg #(.W(72)) u_w (
    .clk(clk), .rst(rst), .i_en(w_en), .i_valid(s_axil_wvalid), .i_data({s_axil_wstrb, s_axil_wdata}),
    .i_clr(w_b_done), .o_ready(s_axil_wready), .o_held(w_w_held), .o_data(w_wd)
  );
  tlk2711_axil_hold_reg #(.W(AXI_ADDR_WIDTH)) u_ar (
    .clk(clk), .rst(rst), .i_en(w_en), .i_valid(s_axil_arvalid), .i_data(s_axil_araddr),
    .i_clr(w_r_done), .o_ready(s_axil_arready), .o_held(w_ar_held), .o_data(w_araddr)
  );
  assign w_wr_resp = access_resp(RANGE_EN && (w_awaddr >= REG_SPAN),
                                 (w_awaddr[2:0] != 3'd0) || (w_wd[71:64] != 8'hFF));
  assign w_rd_resp = access_resp(RANGE_EN && (w_araddr >= REG_SPAN), w_araddr[2:0] != 3'd0);
  // round-robin: a write wins a tie only when the previous grant was a read
  assign w_gnt_wr = w_idle & w_aw_held & w_w_held & (~w_ar_held | ~r_last_wr);
  assign w_gnt_rd = w_idle & w_ar_held & ~w_gnt_wr;
  assign w_cap    = ((r_state == ST_RD_STROBE) && (LAT == 2'd0)) ||
                    ((r_state == ST_RD_WAIT) && (r_cnt == LAT));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = w_gnt_wr ? ((w_wr_resp == RESP_OKAY) ? ST_WR_STROBE : ST_WR_RESP) :
                             w_gnt_rd ? ((w_rd_resp == RESP_OKAY) ? ST_RD_STROBE : ST_RD_RESP) : ST_IDLE;
      ST_WR_STROBE: w_next = ST_WR_RESP;
      ST_WR_RESP:   w_next = s_axil_bready ? ST_IDLE : ST_WR_RESP;
      ST_RD_STROBE,
      ST_RD_WAIT:   w_next = w_cap ? ST_RD_RESP : ST_RD_WAIT;
      ST_RD_RESP:   w_next = s_axil_rready ? ST_IDLE : ST_RD_RESP;
      default:      w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_run     <= 1'b0;
      r_last_wr <= 1'b0;
      r_cnt     <= 2'd0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_run <= 1'b1;
      r_cnt <= (r_state == ST_RD_STROBE) ? 2'd1 : r_cnt + 2'd1;
      if (w_gnt_wr) begin
        r_last_wr <= 1'b1;
        r_bresp   <= w_wr_resp;
      end
      if (w_gnt_rd) begin
        r_last_wr <= 1'b0;
        r_rresp   <= w_rd_resp;
        r_rdata   <= '0;
      end
      if (w_cap) r_rdata <= i_reg_rdata;
    end
  assign s_axil_bvalid = r_state == ST_WR_RESP;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_state == ST_RD_RESP;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rdata;
  assign o_reg_wen     = r_state == ST_WR_STROBE;
  assign o_reg_waddr   = w_awaddr[15:0];
  assign o_reg_wdata   = w_wd[63:0];
  assign o_reg_ren     = r_state == ST_RD_STROBE;
  assign o_reg_raddr   = w_araddr[15:0];
endmodule
